// File: rtl/cache_requester.sv
// Processor-side port into the shared 2-processor cache: command FIFO, one-at-a-time issue,
// response matching and re-issue. Define REQ_TIMEOUT_EN to drop commands after MAX_RETRIES re-issues.
module cache_requester #(
    parameter logic PROC_ID    = 1'b0,
    parameter int   DEPTH_LOG2 = 2
`ifdef REQ_TIMEOUT_EN
    ,
    parameter int   MAX_RETRIES = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_store,
    input  logic [10:0]           cmd_tag,
    input  logic                  cmd_offset,
    input  logic [7:0]            cmd_data,
    output logic [21:0]           request,
    input  logic                  cache_busy,
    input  logic [21:0]           cache_data,
    output logic                  rsp_valid,
    output logic                  rsp_store,
    output logic [10:0]           rsp_tag,
    output logic                  rsp_offset,
    output logic [7:0]            rsp_data,
    output logic [DEPTH_LOG2:0]   pending,
    output logic                  timeout_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic        store;
        logic [10:0] tag;
        logic        offset;
        logic [7:0]  data;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    cmd_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    state_t                state;
    cmd_t                  held;
    logic                  held_valid;
    logic [1:0]            retry;
    logic                  push;
    logic                  pop;
    logic                  match;

    assign cmd_ready = (count != (DEPTH_LOG2 + 1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // A held command (lost arbitration) blocks the FIFO until it completes or is dropped.
    assign pop       = (state == IDLE) && !held_valid && (count != '0) && !cache_busy;
    assign match     = !$isunknown(cache_data) && (cache_data[21] == PROC_ID) &&
                       (cache_data[20:8] == {held.store, held.tag, held.offset});
    assign request   = (state == ISSUE) ? {PROC_ID, held} : 'z;
    assign pending   = count + {{DEPTH_LOG2{1'b0}}, held_valid};

    // NOTE: FIFO storage has no reset; entries are only ever read behind the reset pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_store, cmd_tag, cmd_offset, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            held       <= '0;
            held_valid <= 1'b0;
            retry      <= '0;
            rsp_valid  <= 1'b0;
            rsp_store  <= 1'b0;
            rsp_tag    <= '0;
            rsp_offset <= 1'b0;
            rsp_data   <= '0;
`ifdef REQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        held       <= mem[rd_ptr];
                        held_valid <= 1'b1;
                        state      <= ISSUE;
                    end else if (held_valid && !cache_busy) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    state <= IDLE;
                    if (match) begin
                        rsp_valid  <= 1'b1;
                        rsp_store  <= held.store;
                        rsp_tag    <= held.tag;
                        rsp_offset <= held.offset;
                        rsp_data   <= cache_data[7:0];
                        held_valid <= 1'b0;
                        retry      <= '0;
                    end
`ifdef REQ_TIMEOUT_EN
                    else if (int'(retry) == MAX_RETRIES) begin
                        held_valid  <= 1'b0;
                        timeout_err <= 1'b1;
                        retry       <= '0;
                    end
`endif
                    else if (retry != 2'b11) begin
                        retry <= retry + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef REQ_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: a queue-and-timestamp model of the requester plus a small byte
// cache that answers its requests, compared against the DUT every cycle.
module tb_cache_requester;
    localparam logic PROC_ID    = 1'b0;
    localparam int   DEPTH_LOG2 = 2;
    localparam int   DEPTH      = 1 << DEPTH_LOG2;
`ifdef REQ_TIMEOUT_EN
    localparam int   MAX_RETRIES = 3;
`endif

    typedef struct packed {
        logic        store;
        logic [10:0] tag;
        logic        offset;
        logic [7:0]  data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid;
    logic cmd_store;
    logic [10:0] cmd_tag;
    logic cmd_offset;
    logic [7:0] cmd_data;
    logic cache_busy;
    logic [21:0] cache_data;
    logic cmd_ready;
    wire [21:0] request;
    logic rsp_valid;
    logic rsp_store;
    logic [10:0] rsp_tag;
    logic rsp_offset;
    logic [7:0] rsp_data;
    logic [DEPTH_LOG2:0] pending;
    logic timeout_err;

    cache_requester #(.PROC_ID(PROC_ID), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_store(cmd_store), .cmd_tag(cmd_tag), .cmd_offset(cmd_offset), .cmd_data(cmd_data),
        .request(request), .cache_busy(cache_busy), .cache_data(cache_data),
        .rsp_valid(rsp_valid), .rsp_store(rsp_store), .rsp_tag(rsp_tag),
        .rsp_offset(rsp_offset), .rsp_data(rsp_data), .pending(pending),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total;
    int bad;
    bit checking;
    int busy_pct;
    int bad_pct;
    bit force_busy;
    bit wrong_id;

    // Model: queue of outstanding commands (front may be the one in flight), edge timestamps.
    cmd_t mq[$];
    bit   front_issued;
    int   retries;
    int   n_edge;
    int   next_free;
    int   resp_edge;
    bit   m_req_drive;
    logic [21:0] m_req_word;
    bit   m_rsp_valid;
    bit   m_timeout;
    logic m_rsp_store;
    logic [10:0] m_rsp_tag;
    logic m_rsp_offset;
    logic [7:0] m_rsp_data;
    logic [7:0] cmem [logic [11:0]];
    bit   ready_now;
    cmd_t mf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_match(input logic [21:0] d, input cmd_t c);
        return !$isunknown(d) && (d[21] == PROC_ID) && (d[20:8] == {c.store, c.tag, c.offset});
    endfunction

    function automatic bit idle_ok(input logic [21:0] r);
        return (r === 22'bz) || (r === 22'b0);
    endfunction

    function automatic logic [7:0] mem_rd(input logic [11:0] k);
        if (cmem.exists(k)) return cmem[k];
        return k[7:0] ^ 8'h3C;
    endfunction

    function automatic bit model_ready();
        return (mq.size() - int'(front_issued)) < DEPTH;
    endfunction

    always @(posedge clk) begin
        ready_now = model_ready();
        n_edge++;
        m_rsp_valid = 1'b0;
        m_timeout   = 1'b0;
        m_req_drive = 1'b0;
        if (!rst_n) begin
            mq.delete();
            front_issued = 1'b0;
            retries      = 0;
            next_free    = 0;
            resp_edge    = -1;
            m_rsp_store  = 1'b0;
            m_rsp_tag    = '0;
            m_rsp_offset = 1'b0;
            m_rsp_data   = '0;
        end else begin
            if (n_edge == resp_edge) begin
                mf = mq[0];
                resp_edge = -1;
                if (is_match(cache_data, mf)) begin
                    m_rsp_valid  = 1'b1;
                    m_rsp_store  = mf.store;
                    m_rsp_tag    = mf.tag;
                    m_rsp_offset = mf.offset;
                    m_rsp_data   = cache_data[7:0];
                    if (mf.store) cmem[{mf.tag, mf.offset}] = cache_data[7:0];
                    void'(mq.pop_front());
                    front_issued = 1'b0;
                    retries      = 0;
                end
`ifdef REQ_TIMEOUT_EN
                else if (retries == MAX_RETRIES) begin
                    m_timeout = 1'b1;
                    void'(mq.pop_front());
                    front_issued = 1'b0;
                    retries      = 0;
                end
`endif
                else if (retries < 3) begin
                    retries++;
                end
            end else if (n_edge >= next_free && mq.size() > 0 && !cache_busy) begin
                m_req_drive  = 1'b1;
                m_req_word   = {PROC_ID, mq[0]};
                front_issued = 1'b1;
                resp_edge    = n_edge + 2;
                next_free    = n_edge + 3;
            end
            if (cmd_valid && ready_now) mq.push_back({cmd_store, cmd_tag, cmd_offset, cmd_data});
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cmd_ready", 32'(cmd_ready), 32'(model_ready()));
            check("pending", 32'(pending), 32'(mq.size()));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            check("rsp_store", 32'(rsp_store), 32'(m_rsp_store));
            check("rsp_tag", 32'(rsp_tag), 32'(m_rsp_tag));
            check("rsp_offset", 32'(rsp_offset), 32'(m_rsp_offset));
            check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
            check("timeout_err", 32'(timeout_err), 32'(m_timeout));
            if (m_req_drive) check("request", 32'(request), 32'(m_req_word));
            else             check("request_idle", 32'(idle_ok(request)), 32'd1);
        end
    end

    // The cache: answers the front command correctly unless told to misbehave.
    task automatic drive_cache();
        cmd_t f;
        logic [21:0] w;
        int idx;
        cache_busy = force_busy || ($urandom_range(0, 99) < busy_pct);
        if (mq.size() > 0) begin
            f = mq[0];
            w = {PROC_ID, f.store, f.tag, f.offset, f.store ? f.data : mem_rd({f.tag, f.offset})};
            if (wrong_id) begin
                w[21] = ~w[21];
            end else if ($urandom_range(0, 99) < bad_pct) begin
                case ($urandom_range(0, 2))
                    0: w[21] = ~w[21];
                    1: begin
                        idx = 8 + int'($urandom_range(0, 12));
                        w[idx] = ~w[idx];
                    end
                    default: w = 22'($urandom);
                endcase
            end
        end else begin
            w = 22'($urandom);
        end
        cache_data = w;
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(negedge clk);
            drive_cache();
        end
    endtask

    task automatic push(input logic st, input logic [10:0] tg, input logic of, input logic [7:0] dt);
        cmd_valid  = 1'b1;
        cmd_store  = st;
        cmd_tag    = tg;
        cmd_offset = of;
        cmd_data   = dt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid === 1'b1) break;
        end
        check({name, "_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int n_req;
        int n_rsp;
        int n;
        bit seen;
        logic [21:0] w4;
        logic [21:0] wa;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_tag = '0; cmd_offset = 1'b0;
        cmd_data = '0; cache_busy = 1'b0; cache_data = '0;
        busy_pct = 0; bad_pct = 0; force_busy = 1'b0; wrong_id = 1'b0;
        checking = 1'b0; total = 0; bad = 0;
        n_edge = 0; next_free = 0; resp_edge = -1; front_issued = 1'b0; retries = 0;
        cmem[{11'h288, 1'b0}] = 8'h65;

        tick(3);
        checking = 1'b1;
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_timeout", 32'(timeout_err), 32'd0);
        check("reset_request_idle", 32'(idle_ok(request)), 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Uncontended load: request one cycle after push, response three cycles after push.
        push(1'b0, 11'h288, 1'b0, 8'h00);
        tick();
        check("t1_request", 32'(request), 32'h51000);
        tick(2);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_data", 32'(rsp_data), 32'h65);

        // Store then load of the same byte.
        push(1'b1, 11'h290, 1'b1, 8'hA5);
        push(1'b0, 11'h290, 1'b1, 8'h00);
        wait_rsp("t2_store");
        check("t2_store_type", 32'(rsp_store), 32'd1);
        check("t2_store_data", 32'(rsp_data), 32'hA5);
        wait_rsp("t2_load");
        check("t2_load_type", 32'(rsp_store), 32'd0);
        check("t2_load_data", 32'(rsp_data), 32'hA5);

        // Busy for three edges holds the issue off.
        tick(3);
        force_busy = 1'b1;
        drive_cache();
        push(1'b0, 11'h123, 1'b0, 8'h00);
        tick(2);
        check("t3_busy_pending", 32'(pending), 32'd1);
        check("t3_busy_idle", 32'(idle_ok(request)), 32'd1);
        force_busy = 1'b0;
        drive_cache();
        tick();
        check("t3_issue", 32'(request), 32'h24600);
        wait_rsp("t3");

        // Lost arbitration: wrong processor id while busy, then a clean re-issue.
        tick(2);
        push(1'b1, 11'h0AA, 1'b1, 8'h5A);
        tick();
        w4 = {PROC_ID, 1'b1, 11'h0AA, 1'b1, 8'h5A};
        check("t4_first_issue", 32'(request), 32'(w4));
        wrong_id = 1'b1;
        force_busy = 1'b1;
        drive_cache();
        n_req = 1;
        n_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (request === w4) n_req++;
            if (rsp_valid === 1'b1) n_rsp++;
        end
        wrong_id = 1'b0;
        force_busy = 1'b0;
        drive_cache();
        for (int i = 0; i < 15; i++) begin
            tick();
            if (request === w4) n_req++;
            if (rsp_valid === 1'b1) n_rsp++;
        end
        check("t4_issues", 32'(n_req), 32'd2);
        check("t4_rsp_count", 32'(n_rsp), 32'd1);

        // Fill while busy: fifth push refused, then in-order drain.
        force_busy = 1'b1;
        drive_cache();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_store = 1'b0; cmd_tag = 11'h300 + 11'(i);
            cmd_offset = 1'b0; cmd_data = 8'h00;
            tick();
        end
        cmd_valid = 1'b0;
        check("t5_ready_full", 32'(cmd_ready), 32'd0);
        check("t5_pending_full", 32'(pending), 32'd4);
        force_busy = 1'b0;
        drive_cache();
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                check($sformatf("t5_order%0d", n), 32'(rsp_tag), 32'(11'h300 + 11'(n)));
                n++;
            end
        end
        check("t5_rsp_count", 32'(n), 32'd4);
        check("t5_pending_end", 32'(pending), 32'd0);

`ifdef REQ_TIMEOUT_EN
        // Never answered: four issues, a drop, then the next command is served.
        tick(2);
        force_busy = 1'b1;
        wrong_id = 1'b1;
        drive_cache();
        push(1'b0, 11'h3A0, 1'b0, 8'h00);
        push(1'b0, 11'h3B0, 1'b0, 8'h00);
        force_busy = 1'b0;
        drive_cache();
        wa = {PROC_ID, 1'b0, 11'h3A0, 1'b0, 8'h00};
        n_req = 0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (request === wa) n_req++;
            if (timeout_err === 1'b1) seen = 1'b1;
        end
        check("t6_timeout_seen", 32'(seen), 32'd1);
        check("t6_issues", 32'(n_req), 32'd4);
        wrong_id = 1'b0;
        drive_cache();
        wait_rsp("t6_next");
        check("t6_next_tag", 32'(rsp_tag), 32'h3B0);
`endif

        // Reset while waiting for the answer drops the command silently.
        tick(2);
        push(1'b0, 11'h155, 1'b1, 8'h00);
        tick(2);
        rst_n = 1'b0;
        tick();
        check("rst_request_idle", 32'(idle_ok(request)), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid === 1'b1) n_rsp++;
        end
        check("rst_no_rsp", 32'(n_rsp), 32'd0);

        // Random traffic with a flaky, often busy cache and occasional resets.
        busy_pct = 30;
        bad_pct = 25;
        for (int i = 0; i < 1500; i++) begin
            cmd_valid  = ($urandom_range(0, 99) < 45);
            cmd_store  = 1'($urandom_range(0, 1));
            cmd_tag    = 11'h100 + 11'($urandom_range(0, 7));
            cmd_offset = 1'($urandom_range(0, 1));
            cmd_data   = cmd_store ? 8'($urandom) : 8'h00;
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        busy_pct = 0;
        bad_pct = 0;
        for (int i = 0; i < 200 && mq.size() > 0; i++) tick();
        check("drain_empty", 32'(mq.size()), 32'd0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
